// File: rtl/result_checker_pkg.sv
// Shared types and default constants for the end-of-test result checker.
package result_checker_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned DEF_SIM_END_ADDR = 'h3fff;
  localparam int          DEF_END_CODE     = -1;
  localparam int unsigned DEF_TEST_START   = 'h2000;
  localparam int unsigned DEF_TIMEOUT      = 100000;

endpackage

// File: rtl/result_checker_golden_rf.sv
// Golden value register file: one write port, one combinational read port.
// Contents are deliberately not reset so a table survives a checker reset.
module golden_rf #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] widx_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] ridx_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/result_checker.sv
// End-of-test checker: snoops DM writes for the end marker or times out,
// then scans a DM window through a 1-cycle-latency read port vs goldens.
module result_checker
  import result_checker_pkg::*;
#(
  parameter int          ADDR_W       = 14,
  parameter int          DATA_W       = 32,
  parameter int          STRB_W       = DATA_W / 8,
  parameter logic [ADDR_W-1:0] SIM_END_ADDR = ADDR_W'(DEF_SIM_END_ADDR),
  parameter logic [DATA_W-1:0] END_CODE     = DATA_W'(DEF_END_CODE),
  parameter logic [ADDR_W-1:0] TEST_START   = ADDR_W'(DEF_TEST_START),
  parameter int          GOLD_DEPTH   = 64,
  parameter int          CYC_W        = 64,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [ADDR_W-1:0]             wr_addr,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic [STRB_W-1:0]             wr_strb,
  input  logic                          gold_we,
  input  logic [$clog2(GOLD_DEPTH)-1:0] gold_idx,
  input  logic [DATA_W-1:0]             gold_data,
  input  logic [$clog2(GOLD_DEPTH):0]   gold_num,
  output logic                          rd_req,
  output logic [ADDR_W-1:0]             rd_addr,
  input  logic [DATA_W-1:0]             rd_data,
  output logic                          mis_valid,
  output logic [$clog2(GOLD_DEPTH)-1:0] mis_idx,
  output logic [DATA_W-1:0]             mis_data,
  output logic [DATA_W-1:0]             mis_exp,
  output logic [$clog2(GOLD_DEPTH):0]   chk_cnt,
  output logic [$clog2(GOLD_DEPTH):0]   err_cnt,
  output logic [CYC_W-1:0]              cycle_cnt,
  output logic                          done,
  output logic                          pass,
  output logic                          timed_out
);

  localparam int IW = $clog2(GOLD_DEPTH);
  localparam int CW = IW + 1;

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CW-1:0]     num_q, num_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              cmp_vld_q, cmp_vld_d;
  logic [IW-1:0]     cmp_idx_q, cmp_idx_d;
  logic [CW-1:0]     chk_q, chk_d;
  logic [CW-1:0]     err_q, err_d;
  logic              mis_vld_q, mis_vld_d;
  logic [IW-1:0]     mis_idx_q, mis_idx_d;
  logic [DATA_W-1:0] mis_data_q, mis_data_d;
  logic [DATA_W-1:0] mis_exp_q, mis_exp_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              tout_q, tout_d;

  logic              end_hit;
  logic              tmo_hit;
  logic [CW-1:0]     num_sat;
  logic              last_req;
  logic              mismatch;
  logic [DATA_W-1:0] gold_rdata;

  golden_rf #(
    .DEPTH  (GOLD_DEPTH),
    .DATA_W (DATA_W)
  ) u_gold (
    .clk     (clk),
    .we_i    (gold_we && (state_q == RUN)),
    .widx_i  (gold_idx),
    .wdata_i (gold_data),
    .ridx_i  (cmp_idx_q),
    .rdata_o (gold_rdata)
  );

  assign end_hit = wr_en
                && (wr_addr == SIM_END_ADDR)
                && (&wr_strb)
                && (wr_data == END_CODE);

  assign tmo_hit = (cyc_q == CYC_W'(TIMEOUT - 1));

  assign num_sat = (gold_num > CW'(GOLD_DEPTH))
                 ? CW'(GOLD_DEPTH) : gold_num;

  assign last_req = (({1'b0, idx_q} + CW'(1)) >= num_q);

  assign mismatch = cmp_vld_q && (rd_data != gold_rdata);

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    num_d      = num_q;
    idx_d      = idx_q;
    rd_req_d   = rd_req_q;
    rd_addr_d  = rd_addr_q;
    cmp_vld_d  = 1'b0;
    cmp_idx_d  = cmp_idx_q;
    chk_d      = chk_q;
    err_d      = err_q;
    mis_vld_d  = 1'b0;
    mis_idx_d  = mis_idx_q;
    mis_data_d = mis_data_q;
    mis_exp_d  = mis_exp_q;
    done_d     = done_q;
    pass_d     = pass_q;
    tout_d     = tout_q;

    // Compare stage runs whenever a read was issued last cycle.
    if (cmp_vld_q) begin
      chk_d = chk_q + CW'(1);
    end
    if (mismatch) begin
      err_d      = err_q + CW'(1);
      mis_vld_d  = 1'b1;
      mis_idx_d  = cmp_idx_q;
      mis_data_d = rd_data;
      mis_exp_d  = gold_rdata;
    end

    unique case (state_q)
      RUN: begin
        if (end_hit || tmo_hit) begin
          tout_d    = !end_hit;
          num_d     = num_sat;
          idx_d     = '0;
          rd_addr_d = TEST_START;
          if (num_sat == '0) begin
            state_d = DRAIN;
          end else begin
            state_d  = SCAN;
            rd_req_d = 1'b1;
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      SCAN: begin
        if (rd_req_q) begin
          cmp_vld_d = 1'b1;
          cmp_idx_d = idx_q;
        end
        if (!rd_req_q || last_req) begin
          rd_req_d = 1'b0;
          state_d  = DRAIN;
        end else begin
          idx_d     = idx_q + IW'(1);
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
        pass_d  = (err_d == '0) && !tout_q;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      cyc_q      <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_idx_q  <= '0;
      chk_q      <= '0;
      err_q      <= '0;
      mis_vld_q  <= 1'b0;
      mis_idx_q  <= '0;
      mis_data_q <= '0;
      mis_exp_q  <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      cmp_vld_q  <= cmp_vld_d;
      cmp_idx_q  <= cmp_idx_d;
      chk_q      <= chk_d;
      err_q      <= err_d;
      mis_vld_q  <= mis_vld_d;
      mis_idx_q  <= mis_idx_d;
      mis_data_q <= mis_data_d;
      mis_exp_q  <= mis_exp_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      tout_q     <= tout_d;
    end
  end

  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign mis_valid = mis_vld_q;
  assign mis_idx   = mis_idx_q;
  assign mis_data  = mis_data_q;
  assign mis_exp   = mis_exp_q;
  assign chk_cnt   = chk_q;
  assign err_cnt   = err_q;
  assign cycle_cnt = cyc_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timed_out = tout_q;

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker with a latency-1 DM model.
module tb_result_checker;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int SW  = 4;
  localparam int GD  = 64;
  localparam int IW  = 6;
  localparam int CW  = 7;
  localparam int CYW = 64;
  localparam int TO  = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [SW-1:0] wr_strb = '0;
  logic          gold_we = 1'b0;
  logic [IW-1:0] gold_idx = '0;
  logic [DW-1:0] gold_data = '0;
  logic [CW-1:0] gold_num = '0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          mis_valid;
  logic [IW-1:0] mis_idx;
  logic [DW-1:0] mis_data;
  logic [DW-1:0] mis_exp;
  logic [CW-1:0] chk_cnt;
  logic [CW-1:0] err_cnt;
  logic [CYW-1:0] cycle_cnt;
  logic          done;
  logic          pass;
  logic          timed_out;

  int checks = 0;
  int errors = 0;
  int rcyc = 0;
  int rdq_n = 0;
  int mis_n = 0;
  logic [AW-1:0] first_addr = '0;
  logic [AW-1:0] last_addr = '0;
  logic [IW-1:0] m_idx = '0;
  logic [DW-1:0] m_data = '0;
  logic [DW-1:0] m_exp = '0;
  logic [DW-1:0] dm [0:16383];

  always #5 clk = ~clk;

  result_checker #(.TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .gold_we   (gold_we),
    .gold_idx  (gold_idx),
    .gold_data (gold_data),
    .gold_num  (gold_num),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .mis_valid (mis_valid),
    .mis_idx   (mis_idx),
    .mis_data  (mis_data),
    .mis_exp   (mis_exp),
    .chk_cnt   (chk_cnt),
    .err_cnt   (err_cnt),
    .cycle_cnt (cycle_cnt),
    .done      (done),
    .pass      (pass),
    .timed_out (timed_out)
  );

  // DM model with one-cycle read latency
  always @(posedge clk) begin
    if (rd_req) rd_data <= dm[rd_addr];
  end

  // cycles since reset release, counted independently of the DUT
  always @(posedge clk) begin
    rcyc <= rst_n ? rcyc + 1 : 0;
  end

  always @(negedge clk) begin
    if (rd_req) begin
      if (rdq_n == 0) first_addr = rd_addr;
      last_addr = rd_addr;
      rdq_n++;
    end
    if (mis_valid) begin
      mis_n++;
      m_idx  = mis_idx;
      m_data = mis_data;
      m_exp  = mis_exp;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdq_n = 0;
    mis_n = 0;
  endtask

  task automatic load_gold(input int i, input logic [DW-1:0] v);
    gold_we   = 1'b1;
    gold_idx  = IW'(i);
    gold_data = v;
    @(negedge clk);
    gold_we = 1'b0;
  endtask

  task automatic send_wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_strb = s;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic fire_at(input int c);
    int g;
    g = 0;
    while (rcyc != c && g < 1000) begin
      @(negedge clk);
      g++;
    end
    send_wr(14'h3fff, 32'hffff_ffff, 4'hf);
  endtask

  // k = negedges after the marker write at which done is first seen
  task automatic wait_done(output int k);
    k = 1;
    while (!done && k < 600) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_wait got done=0 after %0d cycles exp done=1", k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rd_req, mis_valid, done, pass, timed_out} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000",
               {rd_req, mis_valid, done, pass, timed_out});
    end
    checks++;
    if (chk_cnt !== 0 || err_cnt !== 0 || cycle_cnt !== 0 || rd_addr !== 0) begin
      errors++;
      $display("FAIL reset_cnts got chk=%0d err=%0d cyc=%0d addr=%h exp 0",
               chk_cnt, err_cnt, cycle_cnt, rd_addr);
    end
  endtask

  task automatic test_pass();
    int k;
    do_reset();
    for (int i = 0; i < 4; i++) load_gold(i, DW'(i + 1));
    gold_num = 7'd4;
    fire_at(50);
    wait_done(k);
    checks++;
    if (k != 6) begin
      errors++;
      $display("FAIL pass_latency got %0d exp 6", k);
    end
    checks++;
    if (pass !== 1'b1 || timed_out !== 1'b0) begin
      errors++;
      $display("FAIL pass_flag got pass=%b to=%b exp 1 0", pass, timed_out);
    end
    checks++;
    if (err_cnt !== 7'd0 || chk_cnt !== 7'd4) begin
      errors++;
      $display("FAIL pass_cnts got err=%0d chk=%0d exp 0 4", err_cnt, chk_cnt);
    end
    checks++;
    if (cycle_cnt !== 64'd50) begin
      errors++;
      $display("FAIL pass_cycle got %0d exp 50", cycle_cnt);
    end
    checks++;
    if (rdq_n != 4 || mis_n != 0) begin
      errors++;
      $display("FAIL pass_reads got rd=%0d mis=%0d exp 4 0", rdq_n, mis_n);
    end
    checks++;
    if (first_addr !== 14'h2000 || last_addr !== 14'h2003) begin
      errors++;
      $display("FAIL pass_addr got %h..%h exp 2000..2003", first_addr, last_addr);
    end
    // golden writes after DONE must be dropped
    load_gold(0, 32'h99);
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      errors++;
      $display("FAIL done_sticky got done=%b pass=%b exp 1 1", done, pass);
    end
  endtask

  task automatic test_mismatch();
    int k;
    do_reset();
    dm[16'h2002] = 32'hdead;
    gold_num = 7'd4;
    fire_at(20);
    wait_done(k);
    checks++;
    if (mis_n != 1 || m_idx !== 6'd2) begin
      errors++;
      $display("FAIL mis_count got n=%0d idx=%0d exp 1 2", mis_n, m_idx);
    end
    checks++;
    if (m_data !== 32'hdead || m_exp !== 32'd3) begin
      errors++;
      $display("FAIL mis_data got %h/%h exp dead/3", m_data, m_exp);
    end
    checks++;
    if (err_cnt !== 7'd1 || chk_cnt !== 7'd4 || pass !== 1'b0) begin
      errors++;
      $display("FAIL mis_result got err=%0d chk=%0d pass=%b exp 1 4 0",
               err_cnt, chk_cnt, pass);
    end
    dm[16'h2002] = 32'd3;
  endtask

  task automatic test_partial();
    do_reset();
    repeat (5) @(negedge clk);
    send_wr(14'h3fff, 32'hffff_ffff, 4'b0111);
    send_wr(14'h3ffe, 32'hffff_ffff, 4'hf);
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || rdq_n != 0) begin
      errors++;
      $display("FAIL partial_nodet got done=%b rd=%0d exp 0 0", done, rdq_n);
    end
    checks++;
    if (cycle_cnt !== CYW'(rcyc)) begin
      errors++;
      $display("FAIL partial_run got cyc=%0d exp %0d", cycle_cnt, rcyc);
    end
  endtask

  task automatic test_timeout();
    int g;
    int dcyc;
    do_reset();
    gold_num = 7'd4;
    g = 0;
    while (!done && g < 400) begin
      @(negedge clk);
      g++;
    end
    dcyc = rcyc;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || dcyc != 205) begin
      errors++;
      $display("FAIL tmo_done got done=%b at %0d exp 1 at 205", done, dcyc);
    end
    checks++;
    if (cycle_cnt !== 64'd199 || timed_out !== 1'b1) begin
      errors++;
      $display("FAIL tmo_flag got cyc=%0d to=%b exp 199 1", cycle_cnt, timed_out);
    end
    checks++;
    if (pass !== 1'b0 || err_cnt !== 7'd0 || chk_cnt !== 7'd4) begin
      errors++;
      $display("FAIL tmo_result got pass=%b err=%0d chk=%0d exp 0 0 4",
               pass, err_cnt, chk_cnt);
    end
  endtask

  task automatic test_end_at_timeout();
    int k;
    do_reset();
    gold_num = 7'd4;
    fire_at(199);
    wait_done(k);
    checks++;
    if (timed_out !== 1'b0 || pass !== 1'b1 || cycle_cnt !== 64'd199) begin
      errors++;
      $display("FAIL tie_end got to=%b pass=%b cyc=%0d exp 0 1 199",
               timed_out, pass, cycle_cnt);
    end
  endtask

  task automatic test_zero();
    int k;
    do_reset();
    gold_num = 7'd0;
    fire_at(10);
    wait_done(k);
    checks++;
    if (k != 2 || rdq_n != 0) begin
      errors++;
      $display("FAIL zero_timing got k=%0d rd=%0d exp 2 0", k, rdq_n);
    end
    checks++;
    if (pass !== 1'b1 || chk_cnt !== 7'd0) begin
      errors++;
      $display("FAIL zero_result got pass=%b chk=%0d exp 1 0", pass, chk_cnt);
    end
  endtask

  task automatic test_saturate();
    int k;
    do_reset();
    for (int i = 0; i < GD; i++) begin
      dm[16'h2000 + i] = DW'(i + 1);
      load_gold(i, DW'(i + 1));
    end
    gold_num = 7'd70;
    fire_at(80);
    wait_done(k);
    checks++;
    if (rdq_n != 64 || chk_cnt !== 7'd64 || k != 66) begin
      errors++;
      $display("FAIL sat_reads got rd=%0d chk=%0d k=%0d exp 64 64 66",
               rdq_n, chk_cnt, k);
    end
    checks++;
    if (last_addr !== 14'h203f || pass !== 1'b1 || err_cnt !== 7'd0) begin
      errors++;
      $display("FAIL sat_result got last=%h pass=%b err=%0d exp 203f 1 0",
               last_addr, pass, err_cnt);
    end
  endtask

  task automatic test_reset_mid_scan();
    int k;
    do_reset();
    gold_num = 7'd64;
    fire_at(10);
    repeat (4) @(negedge clk);
    checks++;
    if (rd_req !== 1'b1 || chk_cnt === 7'd0) begin
      errors++;
      $display("FAIL mid_active got rd_req=%b chk=%0d exp 1 nonzero",
               rd_req, chk_cnt);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({rd_req, mis_valid, done, pass, timed_out} !== 5'b0 ||
        chk_cnt !== 0 || err_cnt !== 0 || cycle_cnt !== 0) begin
      errors++;
      $display("FAIL mid_reset got flags=%b chk=%0d err=%0d cyc=%0d exp 0",
               {rd_req, mis_valid, done, pass, timed_out},
               chk_cnt, err_cnt, cycle_cnt);
    end
    rst_n = 1'b1;
    rdq_n = 0;
    mis_n = 0;
    @(negedge clk);
    checks++;
    if (cycle_cnt !== 64'd1 || rd_req !== 1'b0) begin
      errors++;
      $display("FAIL mid_run got cyc=%0d rd_req=%b exp 1 0", cycle_cnt, rd_req);
    end
    gold_num = 7'd4;
    send_wr(14'h3fff, 32'hffff_ffff, 4'hf);
    wait_done(k);
    checks++;
    if (k != 6 || pass !== 1'b1 || chk_cnt !== 7'd4 || rdq_n != 4) begin
      errors++;
      $display("FAIL mid_rerun got k=%0d pass=%b chk=%0d rd=%0d exp 6 1 4 4",
               k, pass, chk_cnt, rdq_n);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) dm[i] = '0;
    for (int i = 0; i < 4; i++) dm[16'h2000 + i] = DW'(i + 1);
    test_reset();
    test_pass();
    test_mismatch();
    test_partial();
    test_timeout();
    test_end_at_timeout();
    test_zero();
    test_saturate();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
